imem_program_loader: RTL
========================

Name: imem_program_loader

Overview:
- Upstream of the 5-stage pipeline core.
- Streams program words over a valid/ready interface into instruction memory and holds the core in reset while loading.
- Releases the core after a programmable delay once the last word is written.
- Sits between the external boot source and the core's clk/reset inputs and instruction-memory write port.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; DEPTH = 2**ADDR_WIDTH words
RELEASE_DELAY, 4, cycles core_reset stays high after the final write (1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins (or restarts) a load
in_valid  input  1  boot source has a word
in_data  input  32  program word
in_last  input  1  qualifies the final word of the program
in_ready  output  1  loader accepts a word this cycle
imem_we  output  1  instruction-memory write enable
imem_addr  output  ADDR_WIDTH  word address of the write
imem_wdata  output  32  write data
core_reset  output  1  reset to the pipeline core (active-high)
done  output  1  high while the core is running a loaded program
error  output  1  sticky overflow/checksum error
word_count  output  ADDR_WIDTH+1  words written in the current load

Behaviour:
- Reset values: core_reset=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, word_count=0, state=IDLE.
- Reset asserted mid-load aborts immediately to these values.
- All outputs are registered.
- FSM states: IDLE, LOAD, HOLD, RUN, ERR.
- IDLE: core_reset=1. start -> LOAD. Entering LOAD clears word_count, error and the address counter.
- LOAD: in_ready=1. A transfer is in_valid & in_ready.
  - Each transfer drives imem_we=1, imem_addr=word_count[ADDR_WIDTH-1:0], imem_wdata=in_data on the next cycle (1-cycle latency). word_count increments in that same cycle.
  - Transfer with in_last=1 -> HOLD, with the delay counter loaded to RELEASE_DELAY.
  - Transfer arriving when word_count==DEPTH (memory full): not written -> ERR, error=1.
  - A last word landing at address DEPTH-1 is legal.
  - in_valid=0 holds state; there is no timeout.
- HOLD: in_ready=0, core_reset=1. Counter decrements each cycle; at 0 -> RUN.
- RUN: core_reset=0, done=1, in_ready=0. start -> LOAD; core_reset=1 and done=0 take effect the next cycle.
- ERR: core_reset=1, in_ready=0, error held. start -> LOAD (clears error).
- start in LOAD or HOLD is ignored.
- start in the same cycle as a final transfer: the transfer wins.
- imem_we is high for exactly one cycle per accepted word, never outside LOAD/HOLD entry.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit wrapping sum of all non-last words accumulates during LOAD.
  - The in_last word is the expected checksum and is not written; word_count excludes it.
  - Match -> HOLD. Mismatch -> ERR, error=1.
- Undefined: the in_last word is an ordinary program word and is written.

Decomposition:
- Shared package: state enum (IDLE/LOAD/HOLD/RUN/ERR) and a default DEPTH constant.
- One sub-module, loader_delay_counter: loadable down-counter with a zero flag, used for HOLD.
- The FSM stays in the top.

Test Plan:
1. reset, start, then 3 words 0x20080005, 0x20090003, 0x01095020 (last on the 3rd), RELEASE_DELAY=4 -> writes at addr 0,1,2, each 1 cycle after its transfer; word_count=3; core_reset falls 4 cycles after HOLD entry; done=1.
2. in_valid toggled 1,0,0,1 during LOAD -> exactly 2 writes at consecutive addresses; no gaps in address.
3. ADDR_WIDTH=2: 4 words without last, then a 5th -> 5th not written, error=1, core_reset=1; a subsequent start clears error.
4. In RUN, pulse start -> core_reset=1 next cycle, word_count=0, new load restarts at addr 0.
5. Assert reset mid-load after 2 words -> all outputs at reset values within the same cycle (asynchronous).
6. With LOADER_CHECKSUM_EN: words 1, 2, then last=3 -> 2 writes, RUN. Last=4 instead -> ERR, error=1.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared types for the instruction-memory program loader.
// Holds the loader FSM state encoding and the default memory geometry.
// No logic; imported by the loader top.
package imem_program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    RUN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int DEFAULT_ADDR_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

endpackage

// File: rtl/loader_delay_counter.sv
// Loadable down-counter that times the core-release delay after the last write.
// Latency: load takes effect next cycle; zero reflects the current count combinationally.
// Backpressure: none; decrements whenever dec is high, saturating at zero.
module loader_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // High when the decrement happening this cycle lands the count on zero,
  // so the owner can leave its wait state exactly load_val cycles after loading.
  assign zero = (cnt_q <= WIDTH'(1));

endmodule

// File: rtl/imem_program_loader.sv
// Streams boot words into instruction memory and holds the core in reset until loaded.
// Latency: write appears 1 cycle after transfer; core released RELEASE_DELAY cycles after the last write.
// Backpressure: in_ready high only in LOAD. Optional checksum: define LOADER_CHECKSUM_EN.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [7:0]          DELAY_LOAD = 8'(RELEASE_DELAY);

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_reset_q, core_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  logic xfer;
  logic hold_load;
  logic delay_zero;

  assign xfer = in_valid & in_ready_q;

  loader_delay_counter #(
    .WIDTH (8)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (DELAY_LOAD),
    .dec      (state_q == HOLD),
    .zero     (delay_zero)
  );

  // Next-state and next-output logic; every output is derived for the registered copy.
  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    error_d      = error_q;
    word_count_d = word_count_q;
    hold_load    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    unique case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          state_d      = LOAD;
          word_count_d = '0;
          error_d      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d        = '0;
`endif
        end
      end
      LOAD: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          // The last word carries the expected sum and is never written.
          if (in_last) begin
            if (in_data == sum_q) begin
              state_d   = HOLD;
              hold_load = 1'b1;
            end else begin
              state_d = ERR;
              error_d = 1'b1;
            end
          end else if (word_count_q == FULL_COUNT) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            imem_wdata_d = in_data;
            word_count_d = word_count_q + 1'b1;
            sum_d        = sum_q + in_data;
          end
`else
          if (word_count_q == FULL_COUNT) begin
            state_d = ERR;
            error_d = 1'b1;
          end else begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            imem_wdata_d = in_data;
            word_count_d = word_count_q + 1'b1;
            if (in_last) begin
              state_d   = HOLD;
              hold_load = 1'b1;
            end
          end
`endif
        end
      end
      HOLD: begin
        if (delay_zero) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase

    // Handshake and core control follow the state being entered, so they are registered.
    in_ready_d   = (state_d == LOAD);
    core_reset_d = (state_d != RUN);
    done_d       = (state_d == RUN);
  end

  // State and output registers; reset aborts any load immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule
